// File: rtl/sdc_controller.sv
// Shutdown-circuit controller: closes the SDC relay on an AS request plus a held,
// re-armed activation button while the debounced chain is closed and the watchdog is alive.
module sdc_controller #(
  parameter int N_CHAN      = 4,
  parameter int DEBOUNCE    = 16,
  parameter int WDT_TIMEOUT = 1000,
  parameter int ACT_HOLD    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              as_close_sdc,
  input  logic              as_driving_mode,
  input  logic              ts_act_btn_cockpit,
  input  logic              ts_act_btn_external,
  input  logic              watchdog_kick,
  input  logic [N_CHAN-1:0] sdc_chain_in,
  input  logic              fault_clear,
  output logic              to_sdc_relay,
  output logic              sdc_is_ready,
  output logic [1:0]        state,
  output logic [N_CHAN-1:0] fault_chan,
  output logic              wdt_expired
);

  // state  | meaning
  // OPEN   | relay open, waiting for request + held, re-armed button
  // CLOSED | relay closed, supervising chain and watchdog
  // FAULT  | tripped, holding until fault_clear with a healthy chain
  typedef enum logic [1:0] {
    ST_OPEN   = 2'd0,
    ST_CLOSED = 2'd1,
    ST_FAULT  = 2'd2
  } state_e;

  localparam int SW   = N_CHAN + 3;
  localparam int DB_W = $clog2(DEBOUNCE + 1);
  localparam int WD_W = $clog2(WDT_TIMEOUT + 1);
  localparam int HD_W = $clog2(ACT_HOLD + 1);

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(WDT_TIMEOUT);
  localparam logic [HD_W-1:0] HD_MAX  = HD_W'(ACT_HOLD);
  localparam logic [HD_W-1:0] HD_LAST = HD_W'(ACT_HOLD - 1);

  logic [SW-1:0]                sync1_q, sync1_d, sync2_q, sync2_d;
  logic [N_CHAN-1:0][DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic [N_CHAN-1:0]            filt_q, filt_d;
  logic                         kick_prev_q, kick_prev_d;
  logic [WD_W-1:0]              wdt_cnt_q, wdt_cnt_d;
  logic                         wdt_expired_q, wdt_expired_d;
  logic [HD_W-1:0]              hold_cnt_q, hold_cnt_d;
  logic                         rearm_q, rearm_d;
  state_e                       state_q, state_d;
  logic [N_CHAN-1:0]            fault_chan_q, fault_chan_d;
  logic                         relay_q, relay_d;
  logic                         ready_q, ready_d;

  logic [N_CHAN-1:0] chain_s;
  logic              cock_s, ext_s, kick_s, kick_edge;
  logic              chain_ok, chain_ok_d, btn, hold_inc;

  always_comb begin
    sync1_d = {watchdog_kick, ts_act_btn_external, ts_act_btn_cockpit, sdc_chain_in};
    sync2_d = sync1_q;
    chain_s = sync2_q[N_CHAN-1:0];
    cock_s  = sync2_q[N_CHAN];
    ext_s   = sync2_q[N_CHAN+1];
    kick_s  = sync2_q[N_CHAN+2];

    // A channel only moves after DEBOUNCE consecutive disagreeing samples.
    filt_d   = filt_q;
    db_cnt_d = db_cnt_q;
    for (int c = 0; c < N_CHAN; c++) begin
      if (chain_s[c] == filt_q[c]) begin
        db_cnt_d[c] = '0;
      end else if (db_cnt_q[c] == DB_LAST) begin
        filt_d[c]   = chain_s[c];
        db_cnt_d[c] = '0;
      end else begin
        db_cnt_d[c] = db_cnt_q[c] + 1'b1;
      end
    end

    kick_prev_d = kick_s;
    kick_edge   = kick_s ^ kick_prev_q;
    if (kick_edge)              wdt_cnt_d = '0;
    else if (wdt_cnt_q == WD_MAX) wdt_cnt_d = wdt_cnt_q;
    else                        wdt_cnt_d = wdt_cnt_q + 1'b1;

    wdt_expired_d = wdt_expired_q;
    if (wdt_cnt_d == WD_MAX)
      wdt_expired_d = 1'b1;
    else if (fault_clear && (state_q != ST_CLOSED) && (wdt_cnt_q < WD_MAX))
      wdt_expired_d = 1'b0;

    chain_ok = (&filt_q) & ~wdt_expired_q;
    btn      = as_driving_mode ? ext_s : cock_s;
    hold_inc = (state_q == ST_OPEN) & chain_ok & as_close_sdc & btn & rearm_q;

    if (!hold_inc)               hold_cnt_d = '0;
    else if (hold_cnt_q == HD_MAX) hold_cnt_d = hold_cnt_q;
    else                         hold_cnt_d = hold_cnt_q + 1'b1;

    state_d      = state_q;
    fault_chan_d = fault_chan_q;
    case (state_q)
      ST_OPEN: begin
        if (hold_inc && (hold_cnt_q == HD_LAST)) state_d = ST_CLOSED;
      end
      ST_CLOSED: begin
        // Trip wins over a simultaneous commanded open.
        if (!chain_ok) begin
          state_d      = ST_FAULT;
          fault_chan_d = ~filt_q;
        end else if (!as_close_sdc) begin
          state_d = ST_OPEN;
        end
      end
      ST_FAULT: begin
        if (fault_clear && chain_ok) begin
          state_d      = ST_OPEN;
          fault_chan_d = '0;
        end
      end
      default: state_d = ST_OPEN;
    endcase

    if ((state_d == ST_CLOSED) && (state_q != ST_CLOSED)) rearm_d = 1'b0;
    else if (!btn)                                        rearm_d = 1'b1;
    else                                                  rearm_d = rearm_q;

    chain_ok_d = (&filt_d) & ~wdt_expired_d;
    relay_d    = (state_d == ST_CLOSED);
    ready_d    = chain_ok_d & (state_d != ST_FAULT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      db_cnt_q      <= '0;
      filt_q        <= '0;
      kick_prev_q   <= 1'b0;
      wdt_cnt_q     <= '0;
      wdt_expired_q <= 1'b0;
      hold_cnt_q    <= '0;
      rearm_q       <= 1'b0;
      state_q       <= ST_OPEN;
      fault_chan_q  <= '0;
      relay_q       <= 1'b0;
      ready_q       <= 1'b0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      db_cnt_q      <= db_cnt_d;
      filt_q        <= filt_d;
      kick_prev_q   <= kick_prev_d;
      wdt_cnt_q     <= wdt_cnt_d;
      wdt_expired_q <= wdt_expired_d;
      hold_cnt_q    <= hold_cnt_d;
      rearm_q       <= rearm_d;
      state_q       <= state_d;
      fault_chan_q  <= fault_chan_d;
      relay_q       <= relay_d;
      ready_q       <= ready_d;
    end
  end

  assign to_sdc_relay = relay_q;
  assign sdc_is_ready = ready_q;
  assign state        = state_q;
  assign fault_chan   = fault_chan_q;
  assign wdt_expired  = wdt_expired_q;

endmodule
